// File: rtl/up_down_sweep_ctrl_pkg.sv
// up_down_sweep_ctrl_pkg: shared state encoding and default widths for the sweep controller
package up_down_sweep_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, UP = 2'd2, DOWN = 2'd3} state_t;
    localparam int N_DEF  = 8;
    localparam int CW_DEF = 8;
endpackage

// File: rtl/sweep_bound_cmp.sv
// sweep_bound_cmp: unsigned compares of the counter value against the latched bounds
module sweep_bound_cmp import up_down_sweep_ctrl_pkg::*; #(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] cnt_i,
    input  logic [N-1:0] lo_i,
    input  logic [N-1:0] hi_i,
    output logic         eq_lo_o,
    output logic         eq_hi_o,
    output logic         lt_lo_o
);
    assign eq_lo_o = cnt_i == lo_i;
    assign eq_hi_o = cnt_i == hi_i;
    assign lt_lo_o = cnt_i < lo_i;
endmodule

// File: rtl/up_down_sweep_ctrl.sv
// up_down_sweep_ctrl: drives an external up/down counter in triangle sweeps between latched bounds
module up_down_sweep_ctrl import up_down_sweep_ctrl_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic [N-1:0]  lo,
    input  logic [N-1:0]  hi,
    input  logic [CW-1:0] cycles,
    input  logic [N-1:0]  cnt_q,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cycles_left
);
    state_t        state_q, state_d;
    logic [N-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0] cl_q, cl_d;
    logic          busy_q, done_q, done_d, err_q, err_d;
    logic          eq_lo, eq_hi, lt_lo;

    sweep_bound_cmp #(.N(N)) u_cmp (
        .cnt_i   (cnt_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .eq_lo_o (eq_lo),
        .eq_hi_o (eq_hi),
        .lt_lo_o (lt_lo)
    );

    // cnt_en/cnt_up close the loop with the counter in the same cycle, so they stay combinational
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cl_d    = cl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_en  = 1'b0;
        cnt_up  = 1'b0;
        if (state_q == IDLE) begin
            if (start && !stop && !pause) begin
                err_d   = lo >= hi;
                state_d = (lo < hi) ? SEEK : IDLE;
                lo_d    = (lo < hi) ? lo : lo_q;
                hi_d    = (lo < hi) ? hi : hi_q;
                cl_d    = (lo < hi) ? cycles : cl_q;
            end
        end else if (stop) begin
            state_d = IDLE;
            cl_d    = '0;
        end else if (!pause) begin
            case (state_q)
                SEEK: begin
                    cnt_en  = !eq_lo;
                    cnt_up  = lt_lo;
                    state_d = eq_lo ? UP : SEEK;
                end
                UP: begin
                    cnt_en  = !eq_hi;
                    cnt_up  = 1'b1;
                    state_d = eq_hi ? DOWN : UP;
                end
                DOWN: begin
                    cnt_en = !eq_lo;
                    if (eq_lo) begin
                        state_d = (cl_q == CW'(1)) ? IDLE : UP;
                        cl_d    = (cl_q == '0) ? cl_q : cl_q - CW'(1);
                        done_d  = cl_q == CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            cl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cl_q    <= cl_d;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cycles_left = cl_q;
endmodule

// File: doc/up_down_sweep_ctrl.md
UP_DOWN_SWEEP_CTRL -- requirements
Module: up_down_sweep_ctrl

Interface
REQ-001 Parameter N, default 8, width of counter value and bounds.
REQ-002 Parameter CW, default 8, width of sweep-count register.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a sweep run; sampled only in IDLE.
REQ-006 stop  in  1  abort current run; return to IDLE next edge.
REQ-007 pause  in  1  freeze counting and state while high.
REQ-008 lo  in  N  lower sweep bound, unsigned; latched on accepted start.
REQ-009 hi  in  N  upper sweep bound, unsigned; latched on accepted start.
REQ-010 cycles  in  CW  number of triangle sweeps; 0 = run until stop; latched on accepted start.
REQ-011 cnt_q  in  N  current value of the controlled up/down counter.
REQ-012 cnt_en  out  1  counter advances on next edge when high.
REQ-013 cnt_up  out  1  direction: 1 = increment, 0 = decrement.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 err  out  1  one-cycle pulse on rejected start.
REQ-017 cycles_left  out  CW  remaining sweeps incl. current one.

Function
REQ-018 States SHALL be IDLE, SEEK, UP, DOWN; encoding registered, next-state combinational.
REQ-019 IDLE: start with lo < hi SHALL latch lo/hi/cycles and enter SEEK; start with lo >= hi SHALL pulse err next cycle and stay IDLE.
REQ-020 SEEK: cnt_en=1, cnt_up=(cnt_q < lo_l) while cnt_q != lo_l; when cnt_q == lo_l, cnt_en=0 and next state UP.
REQ-021 UP: cnt_en=1, cnt_up=1 while cnt_q != hi_l; when cnt_q == hi_l, cnt_en=0 and next state DOWN.
REQ-022 DOWN: cnt_en=1, cnt_up=0 while cnt_q != lo_l; when cnt_q == lo_l, cnt_en=0 and sweep ends.
REQ-023 Sweep end: cycles_left==1 -> IDLE with done pulse in first IDLE cycle; cycles_left>1 -> decrement, UP; latched cycles==0 -> UP, cycles_left held at 0.
REQ-024 Counter dwells exactly one cycle (cnt_en=0) at each bound; no overshoot past lo_l or hi_l permitted.
REQ-025 cnt_en/cnt_up SHALL be combinational from state, pause and cnt_q (zero-latency loop); busy/done/err/cycles_left registered.
REQ-026 pause high: cnt_en=0, state and cycles_left held; cnt_up value don't-care.
REQ-027 stop high in SEEK/UP/DOWN: cnt_en=0 that cycle, IDLE next edge, no done pulse, cycles_left cleared.
REQ-028 stop and start same cycle in IDLE: stop wins, start ignored, no err.
REQ-029 stop overrides pause; pause overrides counting.
REQ-030 start while busy SHALL be ignored; bounds changes while busy SHALL have no effect.
REQ-031 Bound compares unsigned, full N bits; no arithmetic wrap occurs since direction always targets a bound.

Reset
REQ-032 reset_n low SHALL force IDLE, cnt_en=0, cnt_up=0, busy=0, done=0, err=0, cycles_left=0, latched bounds 0, regardless of clk.
REQ-033 Reset mid-run SHALL abandon the run without done or err pulse.

Structure
REQ-034 Shared package SHALL hold state encoding (IDLE=0, SEEK=1, UP=2, DOWN=3) and default N/CW constants.
REQ-035 One sub-module sweep_bound_cmp SHALL compute eq_lo, eq_hi, lt_lo from cnt_q and latched bounds.

Verification
REQ-036 Counter at 0, lo=2, hi=5, cycles=1, start -> busy 11 cycles (SEEK 3, UP 4, DOWN 4), cnt_q path 0..2..5..2, done pulse once.
REQ-037 lo=5, hi=5, start -> err one cycle, busy stays 0, cnt_en never high.
REQ-038 Counter at 9, lo=3, hi=6, cycles=2 -> SEEK counts down 9->3, two triangles, cycles_left 2->1->0, done once.
REQ-039 cycles=0, lo=0, hi=3, stop asserted in 3rd UP phase -> IDLE next edge, no done, cycles_left 0.
REQ-040 Pause high 4 cycles mid-UP at cnt_q=4 -> cnt_en=0 for 4 cycles, cnt_q stays 4, resume completes normally.
REQ-041 reset_n low asynchronously mid-DOWN -> all outputs 0 immediately; start after release runs cleanly.
